// File: rtl/cmos_pixel_packer.sv
// -----------------------------------------------------------------------------
// cmos_pixel_packer
//
// Camera-side capture front end for an OV7670-style 8-bit sensor. It sits
// directly upstream of the frame-buffer write FIFO. The block samples the byte
// bus under VSYNC/HREF and pairs consecutive bytes into 16-bit RGB565 words.
// It issues a one-cycle write strobe per pixel and provides a frame window that
// lets the buffer restart its write address.
//
// After init_done rises, the first SKIP_FRAMES frames are discarded while the
// sensor registers settle. Lines whose geometry does not match IMG_WIDTH raise a
// sticky error flag.
//
// Ports:
//   clk          camera pixel clock (PCLK); every register updates on its rising edge
//   rst          synchronous active-high reset
//   init_done    sensor configuration and memory initialisation complete
//   cmos_vsync   high during vertical blanking
//   cmos_href    high while the bytes of a line are valid
//   cmos_data    sensor byte
//   pixel_we     one-cycle strobe; pixel_data is valid while it is high
//   pixel_data   {first byte, second byte} of the pixel
//   frame_valid  high for the active part of a captured frame
//   frame_start  one-cycle pulse at the start of each captured frame
//   frame_cnt    captured-frame counter, wraps 255 -> 0
//   line_err     sticky: a line had the wrong pixel count or an odd byte count
// -----------------------------------------------------------------------------
module cmos_pixel_packer #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        pixel_we,
    output logic [15:0] pixel_data,
    output logic        frame_valid,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        line_err
);

    // The counters get one bit of headroom above what the nominal geometry
    // needs. This lets an over-long line still count past IMG_WIDTH and be
    // flagged, instead of aliasing back onto a legal value.
    localparam int PIX_W  = $clog2(IMG_WIDTH + 1) + 1;
    localparam int LINE_W = $clog2(IMG_HEIGHT + 1) + 1;
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 1) + 1;

    localparam logic [PIX_W-1:0]  PIX_WIDTH  = PIX_W'(IMG_WIDTH);
    localparam logic [PIX_W-1:0]  PIX_MAX    = '1;
    localparam logic [LINE_W-1:0] LINE_LIMIT = LINE_W'(IMG_HEIGHT);
    localparam logic [SKIP_W-1:0] SKIP_TGT   = SKIP_W'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        WAIT,
        CAPTURE
    } state_t;

    state_t              state;
    logic                s1_vs, s1_href, s1_vs_d, s1_href_d;
    logic [7:0]          s1_data;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic                toggle;
    logic [7:0]          hi_byte;
    logic [15:0]         word;
    logic                word_vld;

    logic                vs_rise, vs_fall, href_fall;
    logic                pair_done, in_window;

    // Input stage: one register on the sensor pins. Edges are found by
    // comparing the registered sample with its previous value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_vs     <= 1'b0;
            s1_href   <= 1'b0;
            s1_data   <= 8'd0;
            s1_vs_d   <= 1'b0;
            s1_href_d <= 1'b0;
        end else begin
            s1_vs     <= cmos_vsync;
            s1_href   <= cmos_href;
            s1_data   <= cmos_data;
            s1_vs_d   <= s1_vs;
            s1_href_d <= s1_href;
        end
    end

    assign vs_rise   =  s1_vs   & ~s1_vs_d;
    assign vs_fall   = ~s1_vs   &  s1_vs_d;
    assign href_fall = ~s1_href &  s1_href_d;

    // A byte completes a pixel when it arrives with the toggle set. The pixel
    // is written only while it lies inside the nominal image.
    assign pair_done = (state == CAPTURE) && init_done && s1_href && !s1_vs && toggle;
    assign in_window = (pix_cnt < PIX_WIDTH) && (line_cnt < LINE_LIMIT);

    // Control FSM together with the frame/line bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            toggle      <= 1'b0;
            word_vld    <= 1'b0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            line_err    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            word_vld    <= 1'b0;

            if (!init_done) begin
                // Losing initialisation aborts the frame. The skip sequence
                // starts over, but frame_cnt and line_err are kept.
                state       <= IDLE;
                frame_valid <= 1'b0;
                skip_cnt    <= '0;
                toggle      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        skip_cnt <= '0;
                        toggle   <= 1'b0;
                        state    <= (SKIP_FRAMES > 0) ? SKIP : WAIT;
                    end

                    SKIP: begin
                        if (vs_rise) begin
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                            if (skip_cnt + SKIP_W'(1) == SKIP_TGT)
                                state <= WAIT;
                        end
                    end

                    WAIT: begin
                        if (vs_fall) begin
                            state       <= CAPTURE;
                            frame_valid <= 1'b1;
                            frame_start <= 1'b1;
                            pix_cnt     <= '0;
                            line_cnt    <= '0;
                            toggle      <= 1'b0;
                        end
                    end

                    CAPTURE: begin
                        if (vs_rise) begin
                            // Frame closes. A line cut short by vsync is
                            // dropped without being judged.
                            state       <= WAIT;
                            frame_valid <= 1'b0;
                            frame_cnt   <= frame_cnt + 8'd1;
                            toggle      <= 1'b0;
                        end else if (s1_vs) begin
                            toggle <= 1'b0;         // href during blanking is noise
                        end else if (s1_href) begin
                            if (!toggle) begin
                                toggle <= 1'b1;
                            end else begin
                                toggle   <= 1'b0;
                                word_vld <= in_window;
                                if (pix_cnt != PIX_MAX)
                                    pix_cnt <= pix_cnt + PIX_W'(1);
                            end
                        end else begin
                            toggle <= 1'b0;
                            if (href_fall) begin
                                // An odd trailing byte is dropped silently
                                // but still marks the line as bad.
                                if (line_cnt != LINE_LIMIT)
                                    line_cnt <= line_cnt + LINE_W'(1);
                                pix_cnt <= '0;
                                if (pix_cnt != PIX_WIDTH || toggle)
                                    line_err <= 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Byte-pairing datapath.
    // NOTE: pure data registers carry no reset; their contents are only
    // observed when qualified by a reset-controlled valid bit.
    always_ff @(posedge clk) begin
        if (state == CAPTURE && s1_href && !s1_vs && !toggle)
            hi_byte <= s1_data;
        if (pair_done)
            word <= {hi_byte, s1_data};
    end

    // Output register: second stage of the two-cycle pairing pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_we   <= 1'b0;
            pixel_data <= 16'd0;
        end else begin
            pixel_we <= word_vld & init_done;
            if (word_vld)
                pixel_data <= word;
        end
    end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_cmos_pixel_packer
//
// Directed bench for cmos_pixel_packer with a 4x2 image geometry.
//   dut_a: SKIP_FRAMES = 2 (skip, pairing, geometry errors, init loss)
//   dut_b: SKIP_FRAMES = 0 (frame counter wrap)
//
// Both instances share the same stimulus. Inputs change 1 ns after a falling
// edge, and outputs are observed on falling edges.
// -----------------------------------------------------------------------------
module tb_cmos_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;

    logic        pixel_we_a, frame_valid_a, frame_start_a, line_err_a;
    logic [15:0] pixel_data_a;
    logic [7:0]  frame_cnt_a;
    logic        pixel_we_b, frame_valid_b, frame_start_b, line_err_b;
    logic [15:0] pixel_data_b;
    logic [7:0]  frame_cnt_b;

    always #5 clk = ~clk;

    cmos_pixel_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .SKIP_FRAMES(2)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .pixel_we    (pixel_we_a),
        .pixel_data  (pixel_data_a),
        .frame_valid (frame_valid_a),
        .frame_start (frame_start_a),
        .frame_cnt   (frame_cnt_a),
        .line_err    (line_err_a)
    );

    cmos_pixel_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .SKIP_FRAMES(0)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .pixel_we    (pixel_we_b),
        .pixel_data  (pixel_data_b),
        .frame_valid (frame_valid_b),
        .frame_start (frame_start_b),
        .frame_cnt   (frame_cnt_b),
        .line_err    (line_err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Observation side: strobe log, frame_start count, and blanking monitor.
    int   neg_cnt  = 0;
    int   we_cnt   = 0;
    int   fs_cnt   = 0;
    int   fv_viol  = 0;
    logic vs_prev  = 1'b0;
    int   we_times[$];
    logic [15:0] we_data[$];

    always @(negedge clk) begin
        neg_cnt++;
        if (pixel_we_a) begin
            we_cnt++;
            we_times.push_back(neg_cnt);
            we_data.push_back(pixel_data_a);
        end
        if (frame_start_a)
            fs_cnt++;
        // Once vsync has been high for two sampled cycles, the registered
        // edge has reached the FSM, so frame_valid must already be low.
        if ((frame_valid_a || frame_valid_b) && cmos_vsync && vs_prev)
            fv_viol++;
        vs_prev = cmos_vsync;
    end

    // Stimulus helpers.
    int   b1_time = 0;
    logic b1_seen = 1'b0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Line of nbytes bytes: b0, b1, then 0xA0+i for byte i >= 2.
    task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < nbytes; i++) begin
            tick();
            cmos_href = 1'b1;
            if (i == 0)      cmos_data = b0;
            else if (i == 1) cmos_data = b1;
            else             cmos_data = 8'(8'hA0 + i);
            if (i == 1 && !b1_seen) begin
                b1_time = neg_cnt;
                b1_seen = 1'b1;
            end
        end
        tick();
        cmos_href = 1'b0;
        cmos_data = 8'h00;
        tick();
        tick();
    endtask

    task automatic send_lines(input int nlines, input int nbytes);
        for (int l = 0; l < nlines; l++)
            send_line(nbytes, 8'hA0, 8'hA1);
    endtask

    task automatic vs_pulse();
        tick();
        cmos_vsync = 1'b1;
        tick();
        tick();
        tick();
        cmos_vsync = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        init_done  = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'h00;
        repeat (4) tick();

        check("rst_we",    {31'd0, pixel_we_a},    32'd0);
        check("rst_data",  {16'd0, pixel_data_a},  32'd0);
        check("rst_fv",    {31'd0, frame_valid_a}, 32'd0);
        check("rst_fs",    {31'd0, frame_start_a}, 32'd0);
        check("rst_fcnt",  {24'd0, frame_cnt_a},   32'd0);
        check("rst_err",   {31'd0, line_err_a},    32'd0);

        // Two frames are skipped; the trailing vsync of the second opens capture.
        rst = 1'b0;
        tick();
        init_done = 1'b1;
        we_cnt = 0;
        fs_cnt = 0;
        send_lines(2, 8);
        vs_pulse();
        send_lines(2, 8);
        vs_pulse();
        check("skip_we",   we_cnt, 0);
        check("skip_fs",   fs_cnt, 1);
        check("cap_fv",    {31'd0, frame_valid_a}, 32'd1);
        check("skip_fcnt", {24'd0, frame_cnt_a},   32'd0);

        // First captured frame; line 0 starts with the 0xF8,0x1F pixel.
        we_times.delete();
        we_data.delete();
        b1_seen = 1'b0;
        send_line(8, 8'hF8, 8'h1F);
        send_line(8, 8'hA0, 8'hA1);
        check("f3_we", we_cnt, 8);
        check("f3_fs", fs_cnt, 1);
        check("lat_log", {31'd0, (we_times.size() >= 2)}, 32'd1);
        if (we_times.size() >= 2) begin
            check("lat_cycles", we_times[0] - b1_time, 3);
            check("px0_data",   {16'd0, we_data[0]}, 32'h0000_F81F);
            check("px1_data",   {16'd0, we_data[1]}, 32'h0000_A2A3);
            check("we_single",  we_times[1] - we_times[0], 2);
        end
        vs_pulse();
        check("f3_fcnt", {24'd0, frame_cnt_a}, 32'd1);
        check("f3_err",  {31'd0, line_err_a},  32'd0);

        // Odd byte count: 4 pixels, 9th byte dropped, sticky error.
        we_cnt = 0;
        send_line(9, 8'hA0, 8'hA1);
        check("odd_we",  we_cnt, 4);
        check("odd_err", {31'd0, line_err_a}, 32'd1);
        send_line(8, 8'hA0, 8'hA1);
        vs_pulse();
        send_lines(2, 8);
        check("good_we",    we_cnt, 16);
        check("err_sticky", {31'd0, line_err_a}, 32'd1);
        vs_pulse();
        check("f5_fcnt", {24'd0, frame_cnt_a}, 32'd3);

        // Over-long lines and an extra line: strobes clipped to 4x2.
        we_cnt = 0;
        send_line(12, 8'hA0, 8'hA1);
        check("long0_we", we_cnt, 4);
        send_line(12, 8'hA0, 8'hA1);
        check("long1_we", we_cnt, 8);
        send_line(12, 8'hA0, 8'hA1);
        check("long2_we", we_cnt, 8);
        check("long_err", {31'd0, line_err_a}, 32'd1);
        vs_pulse();
        check("f6_fcnt", {24'd0, frame_cnt_a}, 32'd4);

        // init_done lost mid-line.
        we_cnt = 0;
        tick();
        cmos_href = 1'b1;
        cmos_data = 8'h11;
        tick();
        check("pre_drop_fv", {31'd0, frame_valid_a}, 32'd1);
        init_done = 1'b0;
        cmos_data = 8'h22;
        tick();
        check("drop_fv", {31'd0, frame_valid_a}, 32'd0);
        repeat (5) begin
            tick();
            cmos_data = cmos_data + 8'd1;
        end
        tick();
        cmos_href = 1'b0;
        repeat (3) tick();
        check("drop_we",   we_cnt, 0);
        check("drop_fcnt", {24'd0, frame_cnt_a}, 32'd4);
        check("drop_err",  {31'd0, line_err_a},  32'd1);

        // Re-assert: two frames skipped again, then capture resumes.
        init_done = 1'b1;
        send_lines(2, 8);
        vs_pulse();
        send_lines(2, 8);
        vs_pulse();
        check("reskip_we", we_cnt, 0);
        check("recap_fv",  {31'd0, frame_valid_a}, 32'd1);
        send_lines(2, 8);
        check("recap_we", we_cnt, 8);
        vs_pulse();
        check("recap_fcnt", {24'd0, frame_cnt_a}, 32'd5);

        // Frame counter wrap on the no-skip instance.
        rst       = 1'b1;
        init_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst2_err",  {31'd0, line_err_a},  32'd0);
        check("rst2_fcnt", {24'd0, frame_cnt_b}, 32'd0);
        init_done = 1'b1;
        tick();
        vs_pulse();
        for (int f = 0; f < 256; f++) begin
            send_line(2, 8'hA0, 8'hA1);
            vs_pulse();
            if (f == 254)
                check("wrap_255", {24'd0, frame_cnt_b}, 32'd255);
        end
        check("wrap_0",  {24'd0, frame_cnt_b}, 32'd0);
        check("fv_vsync", fv_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
